// File: rtl/jpeg_quant_zigzag.sv
// jpeg_quant_zigzag: quantises column-major 8x8 DCT blocks with the JPEG luminance table and
// replays them in zigzag order from a ping-pong buffer. Define QZ_ROUND_EN for rounded division.
module jpeg_quant_zigzag (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [14:0] coef,
  input  logic        coef_valid,
  output logic [11:0] out,
  output logic        out_valid,
  output logic        out_last
);

  // round(65536 / Q[n]) for the luminance table, natural (row-major) index n = 8*v + u
  localparam logic [12:0] RecipTable [64] = '{
    13'd4096, 13'd5958, 13'd6554, 13'd4096, 13'd2731, 13'd1638, 13'd1285, 13'd1074,
    13'd5461, 13'd5461, 13'd4681, 13'd3449, 13'd2521, 13'd1130, 13'd1092, 13'd1192,
    13'd4681, 13'd5041, 13'd4096, 13'd2731, 13'd1638, 13'd1150, 13'd950,  13'd1170,
    13'd4681, 13'd3855, 13'd2979, 13'd2260, 13'd1285, 13'd753,  13'd819,  13'd1057,
    13'd3641, 13'd2979, 13'd1771, 13'd1170, 13'd964,  13'd601,  13'd636,  13'd851,
    13'd2731, 13'd1872, 13'd1192, 13'd1024, 13'd809,  13'd630,  13'd580,  13'd712,
    13'd1337, 13'd1024, 13'd840,  13'd753,  13'd636,  13'd542,  13'd546,  13'd649,
    13'd910,  13'd712,  13'd690,  13'd669,  13'd585,  13'd655,  13'd636,  13'd662
  };

  localparam logic [5:0] ZigzagTable [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {StIdle, StRead} state_e;

  logic [5:0]  k_q;
  logic        wbank_q;
  logic        s1_valid_q, s1_sign_q, s1_last_q, s1_bank_q;
  logic [14:0] s1_mag_q;
  logic [5:0]  s1_n_q;
  logic        s2_valid_q, s2_sign_q, s2_last_q, s2_bank_q;
  logic [27:0] s2_prod_q;
  logic [5:0]  s2_n_q;
  logic [27:0] rounded;
  logic [11:0] q_mag, q_val;
  logic [11:0] mem [128];
  logic [1:0]  full_q, full_d;
  state_e      state_q;
  logic [5:0]  z_q;
  logic        rbank_q;
  logic        rd_done;

  // S1 captures magnitude/sign and the transposed index; S2 forms the reciprocal product
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      wbank_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (ena) begin
      s1_valid_q <= coef_valid;
      if (coef_valid) begin
        s1_mag_q  <= coef[14] ? (~coef + 15'd1) : coef;
        s1_sign_q <= coef[14];
        s1_n_q    <= {k_q[2:0], k_q[5:3]};
        s1_last_q <= (k_q == 6'd63);
        s1_bank_q <= wbank_q;
        k_q       <= k_q + 6'd1;
        if (k_q == 6'd63) wbank_q <= ~wbank_q;
      end
      s2_valid_q <= s1_valid_q;
      s2_prod_q  <= 28'(s1_mag_q) * 28'(RecipTable[s1_n_q]);
      s2_sign_q  <= s1_sign_q;
      s2_n_q     <= s1_n_q;
      s2_last_q  <= s1_last_q;
      s2_bank_q  <= s1_bank_q;
    end
  end

  always_comb begin
`ifdef QZ_ROUND_EN
    rounded = s2_prod_q + 28'd32768;
`else
    rounded = s2_prod_q;
`endif
    q_mag = 12'(rounded >> 16);
    q_val = s2_sign_q ? (~q_mag + 12'd1) : q_mag;
  end

  always_ff @(posedge clk) begin
    if (!rst && ena && s2_valid_q) mem[{s2_bank_q, s2_n_q}] <= q_val;
  end

  assign rd_done = (state_q == StRead) && (z_q == 6'd63);

  // A bank's last write sets its flag; the reader frees it after the final zigzag read
  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rbank_q] = 1'b0;
    if (s2_valid_q && s2_last_q) full_d[s2_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      z_q       <= '0;
      rbank_q   <= 1'b0;
      full_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (ena) begin
      full_q    <= full_d;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (full_q[rbank_q]) begin
            state_q <= StRead;
            z_q     <= '0;
          end
        end
        StRead: begin
          out       <= mem[{rbank_q, ZigzagTable[z_q]}];
          out_valid <= 1'b1;
          out_last  <= (z_q == 6'd63);
          z_q       <= z_q + 6'd1;
          if (z_q == 6'd63) begin
            rbank_q <= ~rbank_q;
            if (!full_q[~rbank_q]) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The first write of a new block may share an edge with the final read of that bank
  assert property (@(posedge clk) disable iff (rst)
    (ena && s2_valid_q) |-> (!full_q[s2_bank_q] || (rd_done && (rbank_q == s2_bank_q))));

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Bench for jpeg_quant_zigzag: table vectors, timing sequences and random blocks checked
// against an arithmetic model of quantisation and zigzag ordering.
module tb_jpeg_quant_zigzag;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        coef_valid = 1'b0;
  logic [14:0] coef = '0;
  logic [11:0] out;
  logic        out_valid;
  logic        out_last;

  jpeg_quant_zigzag dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .coef      (coef),
    .coef_valid(coef_valid),
    .out       (out),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct { int val; bit last; } exp_t;
  typedef struct { int e; bit last; } log_t;
  typedef struct { int k; int c; int zi; int want; } vec_t;

`ifdef QZ_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  log_t log_q[$];
  exp_t mon_e;
  int   zz[64];
  int   ecount = 0;
  bit   live = 1'b0;
  int   pos = 0;
  int   blocks_seen = 0;
  int   cur_blk[64];
  int   last_blk[64];
  int   got;

  int qtab[64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  task automatic check(input string name, input int g, input int w);
    n_cmp++;
    if (g != w) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, g, w);
    end
  endtask

  function automatic int quant(int c, int n);
    int r = (65536 + qtab[n] / 2) / qtab[n];
    int m = (c < 0 ? -c : c) * r;
    if (Rnd) m = (m + 32768) / 65536;
    else m = m / 65536;
    return (c < 0) ? -m : m;
  endfunction

  // Input arrives column-major: k = 8*u + v, stored at natural n = 8*v + u
  task automatic push_block(input int c[64]);
    int nat[64];
    for (int k = 0; k < 64; k++) nat[8 * (k % 8) + k / 8] = quant(c[k], 8 * (k % 8) + k / 8);
    for (int z = 0; z < 64; z++) exp_q.push_back(exp_t'{nat[zz[z]], z == 63});
  endtask

  task automatic drive_block(input int c[64], input int p_ena, input int p_val,
                             output int e_last);
    bit acc;
    for (int k = 0; k < 64; k++) begin
      acc = 1'b0;
      while (!acc) begin
        @(posedge clk); #1;
        ena        = ($urandom_range(99) < p_ena);
        coef_valid = ($urandom_range(99) < p_val);
        coef       = 15'(c[k]);
        acc        = ena && coef_valid;
      end
    end
    e_last = ecount + 1;
    push_block(c);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      ena = 1'b1;
      coef_valid = 1'b0;
      cyc++;
    end while (exp_q.size() != 0 && cyc < 400);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic rand_block(output int c[64]);
    for (int j = 0; j < 64; j++) c[j] = int'($urandom_range(32767)) - 16384;
  endtask

  initial forever begin
    @(posedge clk);
    live = ena || rst;
    if (ena) ecount++;
  end

  initial forever begin
    @(negedge clk);
    if (live && out_valid) begin
      got = int'($signed(out));
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("out_val[%0d]", pos), got, mon_e.val);
        check($sformatf("out_last[%0d]", pos), int'(out_last), int'(mon_e.last));
      end
      log_q.push_back(log_t'{ecount, out_last});
      cur_blk[pos] = got;
      pos++;
      if (pos == 64) begin
        last_blk = cur_blk;
        blocks_seen++;
        pos = 0;
      end
    end
    if (rst) pos = 0;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    string vname[8];
    int c[64];
    int e0, e_last, bs, nz, gaps, lastbad, first, zi;

    // Zigzag order derived from anti-diagonal walks, alternating direction
    zi = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= (s < 8 ? 0 : s - 7); r--) begin
          zz[zi] = 8 * r + (s - r);
          zi++;
        end
      end else begin
        for (int r = (s < 8 ? 0 : s - 7); r <= (s < 8 ? s : 7); r++) begin
          zz[zi] = 8 * r + (s - r);
          zi++;
        end
      end
    end

    vecs[0] = '{0, 1000, 0, Rnd ? 63 : 62};        vname[0] = "dc_pos";
    vecs[1] = '{0, -100, 0, -6};                   vname[1] = "dc_neg";
    vecs[2] = '{1, 1200, 2, Rnd ? 100 : 99};       vname[2] = "zz_n8";
    vecs[3] = '{63, 16383, 63, 165};               vname[3] = "range_n63";
    vecs[4] = '{0, -16384, 0, -1024};              vname[4] = "dc_min";
    vecs[5] = '{8, -16384, 1, Rnd ? -1490 : -1489}; vname[5] = "half_n1";
    vecs[6] = '{16, -16384, 5, Rnd ? -1639 : -1638}; vname[6] = "max_mag_n2";
    vecs[7] = '{7, 37, 35, Rnd ? 1 : 0};           vname[7] = "half_n56";

    rst = 1'b1;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", int'($signed(out)), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_last", int'(out_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 64; j++) c[j] = 0;
      c[vecs[i].k] = vecs[i].c;
      drive_block(c, 100, 100, e_last);
      drain(vname[i]);
      check(vname[i], last_blk[vecs[i].zi], vecs[i].want);
      nz = 0;
      for (int j = 0; j < 64; j++) if (j != vecs[i].zi && last_blk[j] != 0) nz++;
      check({vname[i], "_others_zero"}, nz, 0);
    end

    // Three continuous blocks: gap-free output and latency from the last input of block 0
    log_q.delete();
    e0 = 0;
    for (int b = 0; b < 3; b++) begin
      rand_block(c);
      drive_block(c, 100, 100, e_last);
      if (b == 0) e0 = e_last;
    end
    drain("b2b");
    check("b2b_count", log_q.size(), 192);
    first = (log_q.size() > 0) ? log_q[0].e : -1000;
    check("b2b_first_latency", first - e0, 4);
    gaps = 0;
    lastbad = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (i > 0 && log_q[i].e != log_q[i - 1].e + 1) gaps++;
      if (log_q[i].last != (i % 64 == 63)) lastbad++;
    end
    check("b2b_gaps", gaps, 0);
    check("b2b_last_pos", lastbad, 0);

    // Reset at k = 30 of block 1 while block 0 replays
    rand_block(c);
    drive_block(c, 100, 100, e_last);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      ena = 1'b1;
      coef_valid = 1'b1;
      coef = 15'($urandom_range(32767));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    coef_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    bs = blocks_seen;
    rand_block(c);
    drive_block(c, 100, 100, e_last);
    drain("post_reset");
    check("post_reset_blocks", blocks_seen - bs, 1);

    // Random blocks with gaps on both ena and coef_valid
    bs = blocks_seen;
    for (int b = 0; b < 200; b++) begin
      rand_block(c);
      drive_block(c, 85, 85, e_last);
    end
    drain("random");
    check("random_blocks", blocks_seen - bs, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
